// File: rtl/sad_pkg.sv
// Shared definitions for the SAD full-search sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default frame / window / width parameters
//   SAD_MAX      : all-ones SAD at the default width ("no candidate yet")
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    UPDATE,
    FINISH
  } state_t;

  localparam int DEF_FRAME_W = 64;
  localparam int DEF_FRAME_H = 64;
  localparam int DEF_WIN_W   = 4;
  localparam int DEF_WIN_H   = 4;
  localparam int DEF_SAD_W   = 13;
  localparam int DEF_ADDR_W  = 32;

  localparam logic [DEF_SAD_W-1:0] SAD_MAX = '1;

endpackage

// File: rtl/sad_pos_counter.sv
// Candidate position stepper for the dual-lane SAD search.
// Holds col (advancing by 2 per step), row, and a row pointer
// (base_addr + row*FRAME_W built up by repeated addition, no multiplier).
// Ports:
//   Clk, Reset   : clock, synchronous active-low reset
//   clear        : restart at position (0,0) with row pointer = base_addr
//   advance      : move to the next lane-pair position
//   base_addr    : frame origin, loaded on clear
//   next_addr    : lane-A address of the position after the current one
//   last_in_row  : current step is the final step of its row
//   last_pos     : current step is the final step of the frame
//   b_invalid    : lane B of the current step lies past the last column
module sad_pos_counter
  import sad_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int WIN_W   = DEF_WIN_W,
  parameter int WIN_H   = DEF_WIN_H,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last_in_row,
  output logic              last_pos,
  output logic              b_invalid
);

  localparam int NC    = FRAME_W - WIN_W + 1;
  localparam int NR    = FRAME_H - WIN_H + 1;
  localparam int COL_W = $clog2(NC + 2);
  localparam int ROW_W = $clog2(NR + 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_ptr;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    last_in_row = (int'(col) + 2 >= NC);
    b_invalid   = (int'(col) + 1 == NC);
    last_pos    = last_in_row && (int'(row) == NR - 1);
    if (last_in_row) next_addr = row_ptr + ADDR_W'(FRAME_W);
    else             next_addr = row_ptr + ADDR_W'(int'(col) + 2);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      col     <= '0;
      row     <= '0;
      row_ptr <= '0;
    end else if (clear) begin
      col     <= '0;
      row     <= '0;
      row_ptr <= base_addr;
    end else if (advance) begin
      if (last_in_row) begin
        col     <= '0;
        row     <= row + ROW_W'(1);
        row_ptr <= row_ptr + ADDR_W'(FRAME_W);
      end else begin
        col     <= col + COL_W'(2);
      end
    end
  end

endmodule

// File: rtl/sad_search_sequencer.sv
// Full-search SAD motion-estimation sequencer for a dual-lane SAD/min datapath.
// Walks every window position row-major, two adjacent candidates per step,
// handshakes each step with the SAD engine, drives the min-register controls
// and keeps a shadow copy of the best SAD and its address.
// Ports:
//   Clk, Reset          : clock, synchronous active-low reset
//   start, base_addr    : begin a search at frame origin base_addr
//   busy, done          : search in progress / one-cycle completion pulse
//   sad_req, sad_ack    : SAD engine handshake
//   sad_addr, sad_stride: lane-A candidate address, lane-B offset (1)
//   sad_a, sad_b        : returned SAD values for lanes A and B
//   window_shift, frame_shift, min_in, load_min : datapath min-register controls
//   best_sad, best_addr : running minimum and its candidate address
module sad_search_sequencer
  import sad_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int WIN_W   = DEF_WIN_W,
  parameter int WIN_H   = DEF_WIN_H,
  parameter int SAD_W   = DEF_SAD_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              sad_req,
  input  logic              sad_ack,
  output logic [ADDR_W-1:0] sad_addr,
  output logic [9:0]        sad_stride,
  input  logic [SAD_W-1:0]  sad_a,
  input  logic [SAD_W-1:0]  sad_b,
  output logic              window_shift,
  output logic              frame_shift,
  output logic              min_in,
  output logic              load_min,
  output logic [SAD_W-1:0]  best_sad,
  output logic [ADDR_W-1:0] best_addr
);

  localparam logic [SAD_W-1:0] SAD_ALL_ONES = '1;

  state_t            state;
  logic [SAD_W-1:0]  cap_a;
  logic [SAD_W-1:0]  cap_b;
  logic [ADDR_W-1:0] next_addr;
  logic              last_in_row;
  logic              last_pos;
  logic              b_invalid;
  logic              pick_b;
  logic [SAD_W-1:0]  pick_sad;
  logic [ADDR_W-1:0] pick_addr;

  assign sad_stride = 10'd1;

  sad_pos_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .WIN_W   (WIN_W),
    .WIN_H   (WIN_H),
    .ADDR_W  (ADDR_W)
  ) u_pos (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear       (state == IDLE && start),
    .advance     (state == UPDATE),
    .base_addr   (base_addr),
    .next_addr   (next_addr),
    .last_in_row (last_in_row),
    .last_pos    (last_pos),
    .b_invalid   (b_invalid)
  );

  // Lane A wins ties so the earlier (left) candidate is preferred.
  always_comb begin
    pick_b    = (cap_b < cap_a);
    pick_sad  = pick_b ? cap_b : cap_a;
    pick_addr = sad_addr + ADDR_W'(pick_b);
  end

  // NOTE: all state here is sequential and uses non-blocking assignments, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      sad_req      <= 1'b0;
      sad_addr     <= '0;
      window_shift <= 1'b0;
      frame_shift  <= 1'b0;
      min_in       <= 1'b0;
      load_min     <= 1'b0;
      best_sad     <= SAD_ALL_ONES;
      best_addr    <= '0;
      cap_a        <= SAD_ALL_ONES;
      cap_b        <= SAD_ALL_ONES;
    end else begin
      done         <= 1'b0;
      window_shift <= 1'b0;
      frame_shift  <= 1'b0;
      min_in       <= 1'b0;
      load_min     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            sad_req   <= 1'b1;
            sad_addr  <= base_addr;
            best_sad  <= SAD_ALL_ONES;
            best_addr <= base_addr;
          end
        end
        ISSUE: begin
          if (sad_ack) begin
            state        <= UPDATE;
            sad_req      <= 1'b0;
            cap_a        <= sad_a;
            cap_b        <= b_invalid ? SAD_ALL_ONES : sad_b;
            min_in       <= 1'b1;
            frame_shift  <= last_in_row;
            window_shift <= !last_in_row;
          end
        end
        UPDATE: begin
          // Strict compare: an equal later value never displaces the earlier best.
          if (pick_sad < best_sad) begin
            best_sad  <= pick_sad;
            best_addr <= pick_addr;
          end
          if (last_pos) begin
            state    <= FINISH;
            done     <= 1'b1;
            load_min <= 1'b1;
          end else begin
            state    <= ISSUE;
            sad_req  <= 1'b1;
            sad_addr <= next_addr;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
